// File: rtl/wb_defs_pkg.sv
// Shared Wishbone data-bus definitions for the OpenMIPS mini SoC data-memory slave.
// Holds bus widths, the wait-counter width and the responder FSM state type.
package wb_defs_pkg;

  localparam int WbSelBus     = 4;
  localparam int WbDataBus    = 32;
  localparam int WaitCntWidth = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_ram_core.sv
// Single-port synchronous word RAM with per-byte write enables and a registered read port.
// Byte lane i covers data bits [8*i+7:8*i], so sel[3] maps to the MSB byte.
module wb_ram_core
  import wb_defs_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WbSelBus-1:0]   byte_we,
  input  logic [WbDataBus-1:0]  wr_data,
  input  logic                  rd_en,
  output logic [WbDataBus-1:0]  rd_data
);

  logic [WbDataBus-1:0] mem [2**ADDR_WIDTH];

  // No reset on the array or read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WbSelBus; i++) begin
      if (byte_we[i]) begin
        mem[addr][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
    if (rd_en) begin
      rd_data <= mem[addr];
    end
  end

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone-classic data-memory responder: configurable wait states, big-endian byte-lane
// writes, and error termination for word addresses outside the RAM.
module wb_ram_slave
  import wb_defs_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [WbSelBus-1:0]  wb_sel_i,
  input  logic [WbDataBus-1:0] wb_dat_i,
  output logic [WbDataBus-1:0] wb_dat_o,
  output logic                 wb_ack_o,
  output logic                 wb_err_o
);

  localparam logic [WaitCntWidth-1:0] WaitLoad =
    (WAIT_STATES > 0) ? WaitCntWidth'(WAIT_STATES - 1) : '0;

  wb_state_e               state, state_next;
  logic [WaitCntWidth-1:0] wait_cnt, wait_cnt_next;
  logic                    enter_resp;
  logic                    latch;

  logic [29:0]             adr_q;
  logic                    we_q;
  logic [WbSelBus-1:0]     sel_q;
  logic [WbDataBus-1:0]    dat_q;

  logic                    ack_q, err_q, rd_q;

  logic [29:0]             adr_eff;
  logic                    we_eff;
  logic [WbSelBus-1:0]     sel_eff;
  logic [WbDataBus-1:0]    dat_eff;
  logic                    in_range;
  logic [WbSelBus-1:0]     byte_we;
  logic                    rd_en;
  logic [WbDataBus-1:0]    core_rd_data;

  logic                    unused_adr_bits;
  assign unused_adr_bits = ^wb_adr_i[1:0];

  // With zero wait states the RAM access happens on the request edge itself,
  // so the live bus fields are used while idle and the latched copy afterwards.
  assign adr_eff  = (state == IDLE) ? wb_adr_i[31:2] : adr_q;
  assign we_eff   = (state == IDLE) ? wb_we_i        : we_q;
  assign sel_eff  = (state == IDLE) ? wb_sel_i       : sel_q;
  assign dat_eff  = (state == IDLE) ? wb_dat_i       : dat_q;
  assign in_range = ((adr_eff >> ADDR_WIDTH) == '0);

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    enter_resp    = 1'b0;
    latch         = 1'b0;
    case (state)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          latch = 1'b1;
          if (WAIT_STATES == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next    = WAIT;
            wait_cnt_next = WaitLoad;
          end
        end
      end
      WAIT: begin
        if (!wb_cyc_i) begin
          state_next    = IDLE;
          wait_cnt_next = '0;
        end else if (wait_cnt == '0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt - 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next    = IDLE;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Writes are qualified with rst so nothing reaches the array while reset is held.
  assign byte_we = (enter_resp && we_eff && in_range && rst) ? sel_eff : '0;
  assign rd_en   = enter_resp && !we_eff && in_range;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
      adr_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      dat_q    <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      ack_q    <= enter_resp && in_range;
      err_q    <= enter_resp && !in_range;
      rd_q     <= enter_resp && in_range && !we_eff;
      if (latch) begin
        adr_q <= wb_adr_i[31:2];
        we_q  <= wb_we_i;
        sel_q <= wb_sel_i;
        dat_q <= wb_dat_i;
      end
    end
  end

  wb_ram_core #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_core (
    .clk    (clk),
    .addr   (adr_eff[ADDR_WIDTH-1:0]),
    .byte_we(byte_we),
    .wr_data(dat_eff),
    .rd_en  (rd_en),
    .rd_data(core_rd_data)
  );

  // Read data is shown only during a read acknowledge; all other cycles drive zero.
  assign wb_dat_o = rd_q ? core_rd_data : '0;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;

endmodule
